// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - host-side byte interface of the i2c_target
interface i2c_target_if;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       tx_req;
    logic       addressed;
    logic       rw;
    logic       stop_tick;

    modport slave (
        input  data_in,
        output data_out, rx_valid, tx_req, addressed, rw, stop_tick
    );

    modport master (
        output data_in,
        input  data_out, rx_valid, tx_req, addressed, rw, stop_tick
    );
endinterface

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - single-address I2C target; I2C_TARGET_GENERAL_CALL_EN also ACKs address byte 8'h00
module i2c_target #(
    parameter logic [6:0] OWN_ADDR = 7'h42
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           SCL,
    inout  wire            SDA,
    i2c_target_if.slave    host
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
    } state_t;

    state_t     state_q, state_n;
    logic [2:0] scl_sync, sda_sync;
    logic [3:0] bit_cnt_q, bit_cnt_n;
    logic [7:0] shift_q, shift_n;
    logic [7:0] data_out_q, data_out_n;
    logic       sda_low_q, sda_low_n;
    logic       ack_phase_q, ack_phase_n;
    logic       addressed_q, addressed_n;
    logic       rw_q, rw_n;
    logic       rx_valid_q, rx_valid_n;
    logic       tx_req_q, tx_req_n;
    logic       stop_tick_q, stop_tick_n;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, sda_rise, sda_fall;
    logic       start_det, stop_det;
    logic [7:0] rx_byte;
    logic       addr_match;

    // Open-drain: only ever pull low or float.
    assign SDA = sda_low_q ? 1'b0 : 1'bz;

    assign scl_s    = scl_sync[1];
    assign sda_s    = sda_sync[1];
    assign scl_rise =  scl_sync[1] & ~scl_sync[2];
    assign scl_fall = ~scl_sync[1] &  scl_sync[2];
    assign sda_rise =  sda_sync[1] & ~sda_sync[2];
    assign sda_fall = ~sda_sync[1] &  sda_sync[2];

    // An SCL edge in the same clk masks SDA edges so data bits never look like START/STOP.
    assign start_det = sda_fall & scl_s & ~scl_rise & ~scl_fall;
    assign stop_det  = sda_rise & scl_s & ~scl_rise & ~scl_fall;

    assign rx_byte = {shift_q[6:0], sda_s};

`ifdef I2C_TARGET_GENERAL_CALL_EN
    assign addr_match = (rx_byte[7:1] == OWN_ADDR) || (rx_byte == 8'h00);
`else
    assign addr_match = (rx_byte[7:1] == OWN_ADDR);
`endif

    // Synchronisers idle high so the bus' idle level produces no edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], SCL};
            sda_sync <= {sda_sync[1:0], SDA};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            data_out_q  <= 8'h00;
            sda_low_q   <= 1'b0;
            ack_phase_q <= 1'b0;
            addressed_q <= 1'b0;
            rw_q        <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            stop_tick_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            bit_cnt_q   <= bit_cnt_n;
            shift_q     <= shift_n;
            data_out_q  <= data_out_n;
            sda_low_q   <= sda_low_n;
            ack_phase_q <= ack_phase_n;
            addressed_q <= addressed_n;
            rw_q        <= rw_n;
            rx_valid_q  <= rx_valid_n;
            tx_req_q    <= tx_req_n;
            stop_tick_q <= stop_tick_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        bit_cnt_n   = bit_cnt_q;
        shift_n     = shift_q;
        data_out_n  = data_out_q;
        sda_low_n   = sda_low_q;
        ack_phase_n = ack_phase_q;
        addressed_n = addressed_q;
        rw_n        = rw_q;
        rx_valid_n  = 1'b0;
        tx_req_n    = 1'b0;
        stop_tick_n = 1'b0;

        if (start_det) begin
            state_n     = ADDR;
            bit_cnt_n   = 4'd0;
            addressed_n = 1'b0;
            sda_low_n   = 1'b0;
            ack_phase_n = 1'b0;
        end else if (stop_det) begin
            state_n     = IDLE;
            sda_low_n   = 1'b0;
            ack_phase_n = 1'b0;
            stop_tick_n = addressed_q;
            addressed_n = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_n = rx_byte;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_n = 4'd8;
                            if (addr_match) begin
                                rw_n    = rx_byte[0];
                                state_n = ADDR_ACK;
                            end else begin
                                state_n = IGNORE;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ADDR_ACK, RX_ACK: begin
                    // Phase 0 waits for the fall ending bit 8; phase 1 holds ACK through the 9th clock.
                    if (!ack_phase_q) begin
                        if (scl_fall) begin
                            sda_low_n   = 1'b1;
                            ack_phase_n = 1'b1;
                            if (state_q == ADDR_ACK)
                                addressed_n = 1'b1;
                        end
                    end else begin
                        if (scl_rise && state_q == ADDR_ACK && rw_q)
                            tx_req_n = 1'b1;
                        if (scl_fall) begin
                            ack_phase_n = 1'b0;
                            bit_cnt_n   = 4'd0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                shift_n   = host.data_in;
                                sda_low_n = ~host.data_in[7];
                                state_n   = TX;
                            end else begin
                                sda_low_n = 1'b0;
                                state_n   = RX;
                            end
                        end
                    end
                end
                RX: begin
                    if (scl_rise) begin
                        shift_n = rx_byte;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_n  = 4'd8;
                            data_out_n = rx_byte;
                            rx_valid_n = 1'b1;
                            state_n    = RX_ACK;
                        end else begin
                            bit_cnt_n = bit_cnt_q + 4'd1;
                        end
                    end
                end
                TX: begin
                    // Bit 7 went out on the ACK-exit fall; shift_q[6] is always the next bit.
                    if (scl_fall) begin
                        bit_cnt_n = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            sda_low_n = 1'b0;
                            state_n   = TX_ACK;
                        end else begin
                            sda_low_n = ~shift_q[6];
                            shift_n   = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                TX_ACK: begin
                    if (!ack_phase_q) begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                tx_req_n    = 1'b1;
                                ack_phase_n = 1'b1;
                            end else begin
                                addressed_n = 1'b0;
                                state_n     = IGNORE;
                            end
                        end
                    end else if (scl_fall) begin
                        ack_phase_n = 1'b0;
                        bit_cnt_n   = 4'd0;
                        shift_n     = host.data_in;
                        sda_low_n   = ~host.data_in[7];
                        state_n     = TX;
                    end
                end
                IGNORE: ;
                default: state_n = IDLE;
            endcase
        end
    end

    assign host.data_out  = data_out_q;
    assign host.rx_valid  = rx_valid_q;
    assign host.tx_req    = tx_req_q;
    assign host.addressed = addressed_q;
    assign host.rw        = rw_q;
    assign host.stop_tick = stop_tick_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bench for i2c_target driving a bit-banged I2C master
module tb_i2c_target;
    localparam int Q = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scl = 1'b1;
    logic m_low = 1'b0;
    wire  sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target_if host_if ();

    i2c_target dut (
        .clk   (clk),
        .reset (reset),
        .SCL   (scl),
        .SDA   (sda),
        .host  (host_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int stop_cnt = 0;
    int dut_low_cnt = 0;
    logic [7:0] rx_log[$];
    logic [7:0] tx_data[$];

    always @(negedge clk) begin
        if (host_if.rx_valid) begin
            rx_cnt = rx_cnt + 1;
            rx_log.push_back(host_if.data_out);
        end
        if (host_if.tx_req) begin
            tx_cnt = tx_cnt + 1;
            if (tx_data.size() > 0)
                host_if.data_in = tx_data.pop_front();
        end
        if (host_if.stop_tick)
            stop_cnt = stop_cnt + 1;
        if (!m_low && sda == 1'b0)
            dut_low_cnt = dut_low_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n * Q) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        rx_cnt = 0;
        tx_cnt = 0;
        stop_cnt = 0;
        dut_low_cnt = 0;
        rx_log.delete();
    endtask

    task automatic bus_start();
        m_low = 1'b0;
        wait_q(1);
        scl = 1'b1;
        wait_q(1);
        m_low = 1'b1;
        wait_q(1);
        scl = 1'b0;
        wait_q(1);
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        wait_q(1);
        scl = 1'b1;
        wait_q(1);
        m_low = 1'b0;
        wait_q(2);
    endtask

    task automatic write_bit(input logic b);
        m_low = ~b;
        wait_q(1);
        scl = 1'b1;
        wait_q(2);
        scl = 1'b0;
        wait_q(1);
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0;
        wait_q(1);
        scl = 1'b1;
        wait_q(1);
        b = sda;
        wait_q(1);
        scl = 1'b0;
        wait_q(1);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--)
            write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic [7:0] pattern;

        host_if.data_in = 8'h00;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(negedge clk);

        check("reset_data_out", host_if.data_out, 8'h00);
        check("reset_rx_valid", host_if.rx_valid, 0);
        check("reset_tx_req", host_if.tx_req, 0);
        check("reset_addressed", host_if.addressed, 0);
        check("reset_rw", host_if.rw, 0);
        check("reset_stop_tick", host_if.stop_tick, 0);
        check("reset_sda", sda, 1);

        // Write two bytes
        clear_counts();
        bus_start();
        write_byte(8'h84, ack);
        check("wr_addr_ack", ack, 0);
        check("wr_addressed", host_if.addressed, 1);
        write_byte(8'hA5, ack);
        check("wr_b0_ack", ack, 0);
        write_byte(8'h3C, ack);
        check("wr_b1_ack", ack, 0);
        check("wr_rx_count", rx_cnt, 2);
        check("wr_rx0", (rx_log.size() > 0) ? rx_log[0] : 9'h100, 8'hA5);
        check("wr_rx1", (rx_log.size() > 1) ? rx_log[1] : 9'h100, 8'h3C);
        check("wr_data_out", host_if.data_out, 8'h3C);
        check("wr_addressed_pre_stop", host_if.addressed, 1);
        bus_stop();
        check("wr_stop_tick", stop_cnt, 1);
        check("wr_addressed_post_stop", host_if.addressed, 0);
        check("wr_rw", host_if.rw, 0);

        // Read two bytes, ACK then NACK
        clear_counts();
        tx_data.push_back(8'h5A);
        tx_data.push_back(8'hC3);
        bus_start();
        write_byte(8'h85, ack);
        check("rd_addr_ack", ack, 0);
        check("rd_rw", host_if.rw, 1);
        read_byte(1'b0, rd);
        check("rd_byte0", rd, 8'h5A);
        check("rd_addressed_mid", host_if.addressed, 1);
        read_byte(1'b1, rd);
        check("rd_byte1", rd, 8'hC3);
        check("rd_addressed_nack", host_if.addressed, 0);
        check("rd_tx_req_count", tx_cnt, 2);
        bus_stop();
        check("rd_stop_tick", stop_cnt, 0);

        // Address mismatch
        clear_counts();
        bus_start();
        write_byte(8'h86, ack);
        check("mm_addr_nack", ack, 1);
        write_byte(8'h11, ack);
        check("mm_data_nack", ack, 1);
        check("mm_sda_never_low", dut_low_cnt, 0);
        check("mm_rx_count", rx_cnt, 0);
        check("mm_addressed", host_if.addressed, 0);
        bus_stop();

        // Repeated START: write then read
        clear_counts();
        tx_data.delete();
        tx_data.push_back(8'h99);
        bus_start();
        write_byte(8'h84, ack);
        check("rs_addr_ack", ack, 0);
        write_byte(8'h10, ack);
        check("rs_data_ack", ack, 0);
        check("rs_rx_count", rx_cnt, 1);
        check("rs_rx0", (rx_log.size() > 0) ? rx_log[0] : 9'h100, 8'h10);
        check("rs_rw_write", host_if.rw, 0);
        bus_start();
        write_byte(8'h85, ack);
        check("rs_read_ack", ack, 0);
        check("rs_rw_read", host_if.rw, 1);
        check("rs_tx_req", tx_cnt, 1);
        read_byte(1'b1, rd);
        check("rs_rd_byte", rd, 8'h99);
        bus_stop();

        // STOP after 4 bits of a write byte
        clear_counts();
        bus_start();
        write_byte(8'h84, ack);
        check("ab_addr_ack", ack, 0);
        pattern = 8'hF0;
        for (int i = 7; i >= 4; i--)
            write_bit(pattern[i]);
        bus_stop();
        check("ab_rx_count", rx_cnt, 0);
        check("ab_stop_tick", stop_cnt, 1);
        check("ab_addressed", host_if.addressed, 0);
        // Still idle: a byte without START must not be acknowledged.
        scl = 1'b0;
        wait_q(1);
        write_byte(8'h84, ack);
        check("ab_idle_no_ack", ack, 1);
        bus_stop();

        // Reset while transmitting a 0 bit
        clear_counts();
        tx_data.delete();
        tx_data.push_back(8'h00);
        bus_start();
        write_byte(8'h85, ack);
        check("rst_addr_ack", ack, 0);
        check("rst_sda_driven", sda, 0);
        check("rst_data_out_before", host_if.data_out, 8'h10);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_sda_released", sda, 1);
        check("rst_data_out", host_if.data_out, 8'h00);
        check("rst_addressed", host_if.addressed, 0);
        check("rst_rw", host_if.rw, 0);
        check("rst_rx_valid", host_if.rx_valid, 0);
        check("rst_tx_req", host_if.tx_req, 0);
        check("rst_stop_tick", host_if.stop_tick, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        bus_stop();

        // General call
        clear_counts();
        bus_start();
        write_byte(8'h00, ack);
`ifdef I2C_TARGET_GENERAL_CALL_EN
        check("gc_ack", ack, 0);
        write_byte(8'h77, ack);
        check("gc_data_ack", ack, 0);
        check("gc_data_out", host_if.data_out, 8'h77);
        check("gc_rw", host_if.rw, 0);
`else
        check("gc_nack", ack, 1);
        write_byte(8'h77, ack);
        check("gc_data_nack", ack, 1);
        check("gc_rx_count", rx_cnt, 0);
`endif
        bus_stop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

Single-address I2C target (slave) that responds to the team's single-master `i2c` controller on the same two-wire bus. It detects START, repeated START and STOP, matches a 7-bit address, and ACKs it. It receives write bytes into a byte-wide strobe interface and serves read bytes from a request/data interface. Standard/fast mode only; no clock stretching, no 10-bit addressing.

## Interface
- `OWN_ADDR`, 7'h42: 7-bit target address compared against the first byte after START.
- `clk`  input  1  system clock; must be at least 16x the SCL frequency.
- `reset`  input  1  asynchronous, active-low reset; all registers clear while `reset` = 0.
- `SCL`  input  1  bus clock. The target never drives it.
- `SDA`  inout  1  bus data, open-drain: driven `1'b0` or `1'bZ`, never `1'b1`.
- `data_in`  input  8  byte to transmit; sampled on the SCL falling edge that ends the preceding ACK bit.
- `data_out`  output  8  last received write byte; holds until the next byte completes.
- `rx_valid`  output  1  one-clk pulse when `data_out` updates.
- `tx_req`  output  1  one-clk pulse requesting the next `data_in` byte.
- `addressed`  output  1  high from own-address ACK until STOP, repeated START or master NACK.
- `rw`  output  1  R/W bit of the current transaction (1 = master read).
- `stop_tick`  output  1  one-clk pulse on STOP while `addressed`.

## Operation
- **Input conditioning.** SCL and SDA each pass through a 2-flop synchroniser, then a third flop for edge detection. `scl_rise`, `scl_fall`, `sda_rise` and `sda_fall` are single-clk events.
- **START.** `sda_fall` while synced SCL = 1. From any state, go to ADDR, clear the bit counter and clear `addressed`.
- **STOP.** `sda_rise` while synced SCL = 1. From any state, go to IDLE and release SDA. Pulse `stop_tick` if `addressed` was 1.
- **States and transitions.**
  - IDLE: wait for START.
  - ADDR: shift SDA, MSB first, on each `scl_rise`. After 8 bits, compare bits [7:1] to `OWN_ADDR`.
    - Match: latch `rw` = bit0 and go to ADDR_ACK.
    - Mismatch: go to IGNORE.
  - ADDR_ACK: on the next `scl_fall`, drive SDA low. On the following `scl_fall`, release it.
    - If `rw` = 1, load `data_in` into the shift register and go to TX.
    - Otherwise go to RX.
    - `addressed` rises with the first `scl_fall`. `tx_req` pulses on the `scl_rise` of the ACK bit when `rw` = 1.
  - RX: shift 8 bits on `scl_rise`. On the 8th bit, update `data_out`, pulse `rx_valid` and go to RX_ACK.
  - RX_ACK: always ACK, using the same drive/release rule as ADDR_ACK, then return to RX.
  - TX: on each `scl_fall`, present the next bit, MSB first. Drive low for 0; release for 1. Bit 7 is presented on the `scl_fall` that leaves the ACK. After the 8th bit's `scl_fall`, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on `scl_rise`.
    - 0 (ACK): pulse `tx_req`, load `data_in` on the next `scl_fall`, return to TX.
    - 1 (NACK): clear `addressed` and go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- **Bit counter.** 4 bits, counts 0..8, clears on START and on every ACK-phase exit. No wrap beyond 8.

## Timing
- **Reset values.** state IDLE, SDA released (Z), `data_out` 8'h00, `rx_valid` 0, `tx_req` 0, `addressed` 0, `rw` 0, `stop_tick` 0.
- **Event latency.** Bus-to-event latency is 3 clk (synchroniser plus edge flop).
- **SDA output timing.** SDA output changes 1 clk after `scl_fall`. Data hold after the real SCL fall is therefore 4 clk.
- **Host deadline.** The host must present `data_in` within half an SCL period of `tx_req`; it is not re-sampled.
- **Mid-byte events.**
  - START mid-byte abandons the byte: no `rx_valid`, SDA released in the same clk.
  - STOP mid-byte behaves the same way.
- **Simultaneous edges.** If `sda_*` and `scl_*` events occur in the same clk, the SCL event takes priority and START/STOP detection is suppressed for that clk.
- **Reset mid-transaction.** Assertion releases SDA immediately (asynchronous). After deassertion, stay in IDLE until a fresh START.

## Configuration
- Macro: `I2C_TARGET_GENERAL_CALL_EN`.
- **Defined.** Address byte 8'h00 is also matched and ACKed. `rw` reads 0 and following bytes go through RX/`rx_valid` as normal. Address 8'h01 (a read of the general-call address) is treated as a mismatch and goes to IGNORE.
- **Undefined.** Only `OWN_ADDR` matches; 8'h00 goes to IGNORE.

## Test plan
- **Write two bytes.** START, 0x84 (0x42 write), 0xA5, 0x3C, STOP.
  - Expect ACK on all three bytes.
  - Expect `rx_valid` twice, with `data_out` 0xA5 then 0x3C.
  - Expect `stop_tick` once; `addressed` 1 until STOP.
- **Read two bytes.** START, 0x85; host answers `tx_req` with 0x5A then 0xC3; master ACKs the first byte, NACKs the second, then STOP.
  - Expect SDA to carry 0x5A and 0xC3.
  - Expect 2 `tx_req` pulses.
  - Expect `addressed` to fall at the NACK.
- **Address mismatch.** START, 0x86 (address 0x43), 0x11.
  - Expect SDA Z throughout and no `rx_valid`.
  - Expect `addressed` to stay 0.
- **Repeated START.** START, 0x84, 0x10, repeated START, 0x85.
  - Expect `rx_valid` with 0x10.
  - Expect `rw` to go 0 -> 1 and a `tx_req` pulse.
- **Aborts.**
  - STOP after 4 bits of a write byte: expect no `rx_valid` and state IDLE.
  - `reset` low mid-TX while driving 0: expect SDA Z within the same clk and all outputs at their reset values.
- **General call.** START, 0x00, 0x77.
  - With `I2C_TARGET_GENERAL_CALL_EN` defined: expect ACK and `data_out` 0x77.
  - Without it: expect no ACK.
